ipv4_checksum_update: RTL

- Per-packet IPv4 header checksum verifier and regenerator on the 256-bit AXI4-Stream datapath of the router output-port-lookup pcore.
- Verifies the incoming header checksum, decrements TTL, and writes the recomputed checksum back into the packet.
- Because the IPv4 header straddles beats 0 and 1, beat 0 is held until beat 1 arrives. Exports status counters to the register block.

---
 rtl/ipv4_checksum_update.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ipv4_checksum_update.sv
// ipv4_checksum_update: checks the IPv4 header checksum on a 256-bit AXI4-Stream.
// When enabled, it also decrements TTL and writes the recomputed checksum back.
// Ingress is buffered in a small fall-through FIFO. An IPv4 beat 0 is held
// until beat 1 arrives, because the header straddles the two beats.
// Ports:
//   AXI_ACLK, AXI_RESETN          clock, async active-low reset
//   S_AXIS_*                      ingress stream (TREADY = FIFO not nearly full)
//   M_AXIS_*                      egress stream
//   update_en                     1: TTL decrement + checksum rewrite, 0: verify only
//   pkt_count                     IPv4 candidate packets processed (saturating)
//   bad_csum_count                candidates with a failing received checksum
//   ttl_expired_count             candidates with a good checksum and TTL <= 1
module ipv4_checksum_update #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_FIFO_DEPTH_BITS    = 2
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
  input  logic                                 S_AXIS_TVALID,
  output logic                                 S_AXIS_TREADY,
  input  logic                                 S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
  output logic                                 M_AXIS_TVALID,
  input  logic                                 M_AXIS_TREADY,
  output logic                                 M_AXIS_TLAST,
  input  logic                                 update_en,
  output logic [31:0]                          pkt_count,
  output logic [31:0]                          bad_csum_count,
  output logic [31:0]                          ttl_expired_count
);

  localparam int unsigned DW    = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned PW    = C_FIFO_DEPTH_BITS;
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned DEPTH = 1 << PW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_WAIT1,
    ST_CALC,
    ST_EMIT0,
    ST_EMIT1,
    ST_BODY
  } state_t;

  state_t state, state_nxt;

  // ---------------- ingress fall-through FIFO ----------------
  beat_t          fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_empty, nearly_full, fifo_push, fifo_pop;
  beat_t          head, s_beat;

  assign s_beat        = '{data: S_AXIS_TDATA, strb: S_AXIS_TSTRB, user: S_AXIS_TUSER, last: S_AXIS_TLAST};
  assign fifo_empty    = (fifo_cnt == '0);
  assign nearly_full   = (fifo_cnt >= CW'(DEPTH - 1));
  assign S_AXIS_TREADY = !nearly_full;
  assign fifo_push     = S_AXIS_TVALID && !nearly_full;
  assign head          = fifo_mem[rd_ptr];

  // Storage array carries no reset; reset empties the FIFO through the pointers.
  always_ff @(posedge AXI_ACLK) begin
    if (fifo_push) fifo_mem[wr_ptr] <= s_beat;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- header checksum ----------------
  beat_t        hold0, hold1;
  logic [19:0]  sum_rx, sum_new;
  logic [15:0]  hw, csum_new;
  logic [7:0]   ttl, ttl_dec;
  logic         csum_ok, do_update, is_cand;

  function automatic logic [15:0] fold16(input logic [19:0] s);
    logic [16:0] t;
    t = 17'(s[15:0]) + 17'(s[19:16]);
    return t[15:0] + 16'(t[16]);
  endfunction

  // Sum of the 10 header words: as received, and as rewritten (new TTL, zero checksum)
  always_comb begin
    sum_rx  = '0;
    sum_new = '0;
    hw      = '0;
    ttl     = hold0.data[79:72];
    ttl_dec = ttl - 8'd1;
    for (int i = 0; i < 9; i++) begin
      hw     = hold0.data[143-16*i -: 16];
      sum_rx = sum_rx + 20'(hw);
      if (i == 4)      sum_new = sum_new + 20'({ttl_dec, hw[7:0]});
      else if (i != 5) sum_new = sum_new + 20'(hw);
    end
    sum_rx    = sum_rx  + 20'(hold1.data[255:240]);
    sum_new   = sum_new + 20'(hold1.data[255:240]);
    csum_ok   = (fold16(sum_rx) == 16'hFFFF);
    csum_new  = ~fold16(sum_new);
    do_update = csum_ok && update_en && (ttl > 8'd1);
  end

  assign is_cand = (head.data[159:144] == 16'h0800) && (head.data[143:136] == 8'h45) && !head.last;

  // ---------------- FSM ----------------
  logic  load_hold0, load_hold1, do_calc, m_valid;
  beat_t m_beat;

  // State register
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) state <= ST_HDR;
    else             state <= state_nxt;
  end

  // Next state, FIFO pop and egress mux
  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    load_hold0 = 1'b0;
    load_hold1 = 1'b0;
    do_calc    = 1'b0;
    m_valid    = 1'b0;
    m_beat     = '0;
    unique case (state)
      ST_HDR: begin
        if (!fifo_empty) begin
          if (is_cand) begin
            fifo_pop   = 1'b1;
            load_hold0 = 1'b1;
            state_nxt  = ST_WAIT1;
          end else begin
            m_valid = 1'b1;
            m_beat  = head;
            if (M_AXIS_TREADY) begin
              fifo_pop = 1'b1;
              if (!head.last) state_nxt = ST_BODY;
            end
          end
        end
      end
      ST_WAIT1: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_hold1 = 1'b1;
          state_nxt  = ST_CALC;
        end
      end
      ST_CALC: begin
        do_calc   = 1'b1;
        state_nxt = ST_EMIT0;
      end
      ST_EMIT0: begin
        m_valid = 1'b1;
        m_beat  = hold0;
        if (M_AXIS_TREADY) state_nxt = ST_EMIT1;
      end
      ST_EMIT1: begin
        m_valid = 1'b1;
        m_beat  = hold1;
        if (M_AXIS_TREADY) state_nxt = hold1.last ? ST_HDR : ST_BODY;
      end
      ST_BODY: begin
        if (!fifo_empty) begin
          m_valid = 1'b1;
          m_beat  = head;
          if (M_AXIS_TREADY) begin
            fifo_pop = 1'b1;
            if (head.last) state_nxt = ST_HDR;
          end
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = m_beat.data;
  assign M_AXIS_TSTRB  = m_beat.strb;
  assign M_AXIS_TUSER  = m_beat.user;
  assign M_AXIS_TLAST  = m_beat.last;

  // Hold registers, header rewrite and saturating status counters
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      hold0             <= '0;
      hold1             <= '0;
      pkt_count         <= '0;
      bad_csum_count    <= '0;
      ttl_expired_count <= '0;
    end else begin
      if (load_hold0) hold0 <= head;
      if (load_hold1) hold1 <= head;
      if (do_calc) begin
        if (do_update) begin
          hold0.data[79:72] <= ttl_dec;
          hold0.data[63:48] <= csum_new;
        end
        if (pkt_count != '1) pkt_count <= pkt_count + 32'd1;
        if (!csum_ok && (bad_csum_count != '1))
          bad_csum_count <= bad_csum_count + 32'd1;
        if (csum_ok && (ttl <= 8'd1) && (ttl_expired_count != '1))
          ttl_expired_count <= ttl_expired_count + 32'd1;
      end
    end
  end

endmodule
